// File: rtl/ext_bus_sequencer.sv
// Round-robin arbiter and byte-phase serialiser from NREQ 32-bit masters onto the 8-bit pin bus.
// Sequence per transaction: four address bytes, a control byte, four read-data bytes (reads only), then a one-cycle ack.
module ext_bus_sequencer #(
  parameter int NREQ     = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rw,
  input  logic [32*NREQ-1:0]   addr,
  input  logic [32*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [7:0]           addr_out,
  output logic [7:0]           data_out,
  output logic [7:0]           data_oe,
  input  logic [7:0]           data_in,
  input  logic                 ext_ready
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {IDLE, A0, A1, A2, A3, CTRL, R0, R1, R2, R3, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    rr_ptr, rr_n;
  logic [1:0]    id_l, id_n;
  logic          rw_l, rw_n;
  logic [31:0]   addr_l, addr_n, wdata_l, wdata_n, rbuf, rbuf_n;
  logic          errf, errf_n;
  logic [WW-1:0] wcnt, wcnt_n;

  logic [3:0]    req4;
  logic          gnt_found;
  logic [1:0]    gnt_id;
  logic [2:0]    srch;
  logic [31:0]   gnt_addr, gnt_wdata;
  logic          gnt_rw;

  logic [NREQ-1:0] ack_n;
  logic            err_n, busy_n;
  logic [31:0]     rdata_n;
  logic [7:0]      addr_out_n, data_out_n, data_oe_n;

  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return v[31:24];
    endcase
  endfunction

  assign req4 = 4'(req);

  // First requesting index at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    srch      = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      srch = 3'(rr_ptr) + 3'(k);
      if (srch >= 3'(NREQ)) srch = srch - 3'(NREQ);
      if (!gnt_found && req4[2'(srch)]) begin
        gnt_found = 1'b1;
        gnt_id    = 2'(srch);
      end
    end
  end

  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_rw    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 2'(i)) begin
        gnt_addr  = addr[32*i +: 32];
        gnt_wdata = wdata[32*i +: 32];
        gnt_rw    = rw[i];
      end
    end
  end

  // Next state and next values of every registered output, derived from the state being entered
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    id_n    = id_l;
    rw_n    = rw_l;
    addr_n  = addr_l;
    wdata_n = wdata_l;
    rbuf_n  = rbuf;
    errf_n  = errf;
    wcnt_n  = wcnt;

    case (state)
      IDLE: if (gnt_found) begin
        id_n    = gnt_id;
        rw_n    = gnt_rw;
        addr_n  = gnt_addr;
        wdata_n = gnt_wdata;
        rbuf_n  = '0;
        errf_n  = 1'b0;
        rr_n    = (3'(gnt_id) + 3'd1 == 3'(NREQ)) ? 2'd0 : gnt_id + 2'd1;
        state_n = A0;
      end
      A0: state_n = A1;
      A1: state_n = A2;
      A2: state_n = A3;
      A3: begin
        wcnt_n  = '0;
        state_n = CTRL;
      end
      CTRL: begin
        if (ext_ready) begin
          state_n = rw_l ? R0 : DONE;
        end else if (wcnt == WW'(WAIT_MAX - 1)) begin
          errf_n  = 1'b1;
          state_n = DONE;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      R0: begin rbuf_n[7:0]   = data_in; state_n = R1;   end
      R1: begin rbuf_n[15:8]  = data_in; state_n = R2;   end
      R2: begin rbuf_n[23:16] = data_in; state_n = R3;   end
      R3: begin rbuf_n[31:24] = data_in; state_n = DONE; end
      default: state_n = IDLE;
    endcase

    addr_out_n = '0;
    data_out_n = '0;
    data_oe_n  = '0;
    err_n      = 1'b0;
    rdata_n    = '0;
    ack_n      = '0;
    busy_n     = (state_n != IDLE);
    case (state_n)
      A0, A1, A2, A3: begin
        addr_out_n = byte_sel(addr_n, 2'(state_n - A0));
        if (!rw_n) begin
          data_out_n = byte_sel(wdata_n, 2'(state_n - A0));
          data_oe_n  = 8'hFF;
        end
      end
      CTRL: addr_out_n = {5'b0, id_n, ~rw_n};
      DONE: begin
        err_n   = errf_n;
        rdata_n = errf_n ? 32'd0 : rbuf_n;
        for (int i = 0; i < NREQ; i++) ack_n[i] = (id_n == 2'(i));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id_l     <= '0;
      rw_l     <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      rbuf     <= '0;
      errf     <= 1'b0;
      wcnt     <= '0;
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      data_oe  <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      id_l     <= id_n;
      rw_l     <= rw_n;
      addr_l   <= addr_n;
      wdata_l  <= wdata_n;
      rbuf     <= rbuf_n;
      errf     <= errf_n;
      wcnt     <= wcnt_n;
      ack      <= ack_n;
      err      <= err_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
      addr_out <= addr_out_n;
      data_out <= data_out_n;
      data_oe  <= data_oe_n;
    end
  end

endmodule
